wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports in this order: clk in 1 (sole clock, rising edge); rst in 1 (reset, asynchronous, active-high).
REQ-002 SHALL have requester 0 (ALU writeback) ports: r0_valid in 1; r0_ready out 1; r0_dir in 3 (destination register); r0_scalar in 1 (1 = scalar bank, 0 = vector bank); r0_data in 64.
REQ-003 SHALL have requester 1 (memory load) ports: r1_valid, r1_ready, r1_dir, r1_scalar, r1_data, with the same widths and meanings as requester 0.
REQ-004 SHALL have vector bank write ports: dir_esc out 3; data out 64; signal_esc out 1.
REQ-005 SHALL have scalar bank write ports: dir_escE out 3; dataE out 8; signal_escE out 1.
REQ-006 SHALL have issue reservation ports: alloc_valid in 1; alloc_ready out 1; alloc_dir in 3; alloc_scalar in 1.
REQ-007 SHALL have hazard query ports: dir_A in 3; dir_B in 3; dir_AE in 3; signal_read in 1; signal_readE in 1; stall out 1.

Function
REQ-008 SHALL complete a write transfer on any clock edge where rN_valid and rN_ready are both high.
REQ-009 SHALL drive rN_ready combinationally from current inputs and state; rN_valid SHALL NOT depend on rN_ready.
REQ-010 SHALL grant each requester that is the only one targeting its bank (vector or scalar).
REQ-011 SHALL grant both requesters in the same cycle when one targets the vector bank and the other targets the scalar bank.
REQ-012 When both requesters target the same bank, SHALL grant only the requester that did not win the previous same-bank conflict; the round-robin pointer SHALL update only on such a conflict.
REQ-013 SHALL register the granted write into the bank output registers, so the write appears on the outputs exactly 1 cycle after the handshake.
REQ-014 SHALL assert signal_esc / signal_escE for exactly one cycle per granted write.
REQ-015 SHALL drive dataE from data bits [7:0] of the granted requester.
REQ-016 SHALL hold dir_esc, data, dir_escE and dataE at their last values while the corresponding enable is low.
REQ-017 SHALL keep 16 pending bits, one per register in each bank (8 vector, 8 scalar).
REQ-018 SHALL set pending[alloc_scalar][alloc_dir] on an alloc_valid & alloc_ready edge.
REQ-019 SHALL hold alloc_ready low while the target register is already pending, which blocks write-after-write reservations.
REQ-020 SHALL clear a pending bit on the edge where its signal_esc / signal_escE output is high.
REQ-021 SHALL leave the bit set when a set and a clear of the same bit occur on the same edge (set wins).
REQ-022 SHALL compute stall combinationally as (signal_read & (pend_v[dir_A] | pend_v[dir_B])) | (signal_readE & pend_s[dir_AE]).
REQ-023 SHALL accept writes to non-pending registers and leave the pending state unchanged for them.

Reset
REQ-024 On rst high, SHALL asynchronously force: all pending bits = 0; round-robin pointer = requester 0 has priority; signal_esc = 0; signal_escE = 0; dir_esc = 0; dir_escE = 0; data = 0; dataE = 0.
REQ-025 While rst is high, r0_ready, r1_ready and alloc_ready SHALL be 0.
REQ-026 A handshake in progress when rst asserts SHALL be discarded; no bank write SHALL occur after rst deasserts.

Configuration
REQ-027 Macro WB_SCOREBOARD_EN defined: the scoreboard of REQ-017..REQ-022 SHALL be present.
REQ-028 Macro WB_SCOREBOARD_EN undefined: stall SHALL be tied to 0, alloc_ready SHALL equal !rst, no pending storage SHALL exist, and arbitration SHALL be unchanged.

Structure
REQ-029 Package wb_pkg SHALL hold: NUM_REGS = 8; DIR_W = 3; VDATA_W = 64; SDATA_W = 8; typedef wb_req_t {dir, scalar, data}; enum bank_t {BANK_VEC, BANK_SCA}.
REQ-030 The scoreboard SHALL be a sub-module wb_scoreboard, instantiated only when WB_SCOREBOARD_EN is defined.

Verification
REQ-031 r0 {dir 3, vec, data 0xA5A5_0000_0000_0001} alone -> r0_ready = 1; next cycle signal_esc = 1, dir_esc = 3, data = that value; the cycle after, signal_esc = 0.
REQ-032 r0 vec dir 1 and r1 vec dir 2 valid for 2 cycles after reset -> cycle 1 grants r0, cycle 2 grants r1; signal_esc high for two consecutive cycles with dir_esc = 1, then 2.
REQ-033 r0 vec dir 5 and r1 scalar dir 5 with data 0x..7E, same cycle -> both ready; next cycle signal_esc = 1 and signal_escE = 1, dataE = 0x7E.
REQ-034 alloc vec dir 4, then dir_A = 4 with signal_read = 1 -> stall = 1; second alloc of vec dir 4 -> alloc_ready = 0; r1 write to vec dir 4 -> stall drops in the cycle after signal_esc.
REQ-035 Alloc scalar dir 2 on the same edge where signal_escE clears scalar dir 2 -> pending remains set and stall = 1 with dir_AE = 2, signal_readE = 1.
REQ-036 Assert rst the cycle after an r0 handshake -> signal_esc = 0 immediately, no write after release, and all pending bits = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback arbiter and its register scoreboard.
package wb_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DIR_W    = 3;
  localparam int unsigned VDATA_W  = 64;
  localparam int unsigned SDATA_W  = 8;

  typedef struct packed {
    logic [DIR_W-1:0]   dir;
    logic               scalar;
    logic [VDATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    BANK_VEC = 1'b0,
    BANK_SCA = 1'b1
  } bank_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register in each bank, set at issue
// reservation and cleared when the bank write strobes; drives the read stall.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_valid_i,
  input  logic [DIR_W-1:0] alloc_dir_i,
  input  logic             alloc_scalar_i,
  output logic             alloc_ready_o,
  input  logic             wr_vec_i,
  input  logic [DIR_W-1:0] wr_vec_dir_i,
  input  logic             wr_sca_i,
  input  logic [DIR_W-1:0] wr_sca_dir_i,
  input  logic [DIR_W-1:0] dir_a_i,
  input  logic [DIR_W-1:0] dir_b_i,
  input  logic [DIR_W-1:0] dir_ae_i,
  input  logic             read_i,
  input  logic             read_e_i,
  output logic             stall_o
);

  logic [NUM_REGS-1:0] pend_v_q, pend_v_d;
  logic [NUM_REGS-1:0] pend_s_q, pend_s_d;
  logic                target_pend;
  logic                alloc_fire;

  always_comb begin
    target_pend = alloc_scalar_i ? pend_s_q[alloc_dir_i] : pend_v_q[alloc_dir_i];
    alloc_ready_o = !rst_i && !target_pend;
    alloc_fire = alloc_valid_i && alloc_ready_o;
  end

  // Clears are applied first so a same-edge reservation of the same register wins.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_s_d = pend_s_q;
    if (wr_vec_i) pend_v_d[wr_vec_dir_i] = 1'b0;
    if (wr_sca_i) pend_s_d[wr_sca_dir_i] = 1'b0;
    if (alloc_fire) begin
      if (bank_t'(alloc_scalar_i) == BANK_SCA) pend_s_d[alloc_dir_i] = 1'b1;
      else                                     pend_v_d[alloc_dir_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v_q <= '0;
      pend_s_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_s_q <= pend_s_d;
    end
  end

  always_comb begin
    stall_o = (read_i && (pend_v_q[dir_a_i] || pend_v_q[dir_b_i])) ||
              (read_e_i && pend_s_q[dir_ae_i]);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter for the vector and scalar register banks with
// round-robin on same-bank conflicts. Define WB_SCOREBOARD_EN to add the pending scoreboard.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [DIR_W-1:0]   r0_dir,
  input  logic               r0_scalar,
  input  logic [VDATA_W-1:0] r0_data,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [DIR_W-1:0]   r1_dir,
  input  logic               r1_scalar,
  input  logic [VDATA_W-1:0] r1_data,
  output logic [DIR_W-1:0]   dir_esc,
  output logic [VDATA_W-1:0] data,
  output logic               signal_esc,
  output logic [DIR_W-1:0]   dir_escE,
  output logic [SDATA_W-1:0] dataE,
  output logic               signal_escE,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [DIR_W-1:0]   alloc_dir,
  input  logic               alloc_scalar,
  input  logic [DIR_W-1:0]   dir_A,
  input  logic [DIR_W-1:0]   dir_B,
  input  logic [DIR_W-1:0]   dir_AE,
  input  logic               signal_read,
  input  logic               signal_readE,
  output logic               stall
);

  wb_req_t req0, req1;
  wb_req_t vec_sel, sca_sel;
  logic    conflict, hs0, hs1;
  logic    vec_we, sca_we;
  // rr_q = 0: requester 0 wins the next same-bank conflict.
  logic    rr_q, rr_d;

  logic               sig_v_q, sig_s_q;
  logic [DIR_W-1:0]   dir_v_q, dir_s_q;
  logic [VDATA_W-1:0] data_v_q;
  logic [SDATA_W-1:0] data_s_q;

  always_comb begin
    req0 = '{dir: r0_dir, scalar: r0_scalar, data: r0_data};
    req1 = '{dir: r1_dir, scalar: r1_scalar, data: r1_data};
    conflict = r0_valid && r1_valid && (bank_t'(req0.scalar) == bank_t'(req1.scalar));
    r0_ready = !rst && (!conflict || !rr_q);
    r1_ready = !rst && (!conflict || rr_q);
    hs0 = r0_valid && r0_ready;
    hs1 = r1_valid && r1_ready;
    rr_d = conflict ? hs0 : rr_q;
  end

  always_comb begin
    vec_we  = 1'b0;
    sca_we  = 1'b0;
    vec_sel = req0;
    sca_sel = req0;
    if (hs0 && bank_t'(req0.scalar) == BANK_VEC) begin
      vec_we  = 1'b1;
      vec_sel = req0;
    end else if (hs1 && bank_t'(req1.scalar) == BANK_VEC) begin
      vec_we  = 1'b1;
      vec_sel = req1;
    end
    if (hs0 && bank_t'(req0.scalar) == BANK_SCA) begin
      sca_we  = 1'b1;
      sca_sel = req0;
    end else if (hs1 && bank_t'(req1.scalar) == BANK_SCA) begin
      sca_we  = 1'b1;
      sca_sel = req1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= 1'b0;
      sig_v_q  <= 1'b0;
      sig_s_q  <= 1'b0;
      dir_v_q  <= '0;
      dir_s_q  <= '0;
      data_v_q <= '0;
      data_s_q <= '0;
    end else begin
      rr_q    <= rr_d;
      sig_v_q <= vec_we;
      sig_s_q <= sca_we;
      if (vec_we) begin
        dir_v_q  <= vec_sel.dir;
        data_v_q <= vec_sel.data;
      end
      if (sca_we) begin
        dir_s_q  <= sca_sel.dir;
        data_s_q <= sca_sel.data[SDATA_W-1:0];
      end
    end
  end

  assign signal_esc  = sig_v_q;
  assign dir_esc     = dir_v_q;
  assign data        = data_v_q;
  assign signal_escE = sig_s_q;
  assign dir_escE    = dir_s_q;
  assign dataE       = data_s_q;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk_i          (clk),
    .rst_i          (rst),
    .alloc_valid_i  (alloc_valid),
    .alloc_dir_i    (alloc_dir),
    .alloc_scalar_i (alloc_scalar),
    .alloc_ready_o  (alloc_ready),
    .wr_vec_i       (sig_v_q),
    .wr_vec_dir_i   (dir_v_q),
    .wr_sca_i       (sig_s_q),
    .wr_sca_dir_i   (dir_s_q),
    .dir_a_i        (dir_A),
    .dir_b_i        (dir_B),
    .dir_ae_i       (dir_AE),
    .read_i         (signal_read),
    .read_e_i       (signal_readE),
    .stall_o        (stall)
  );
`else
  logic unused_sb;
  assign unused_sb   = ^{alloc_valid, alloc_dir, alloc_scalar, dir_A, dir_B, dir_AE,
                         signal_read, signal_readE};
  assign alloc_ready = !rst;
  assign stall       = 1'b0;
`endif

endmodule
